// File: rtl/eth_frame_port_if.sv
// Bus bundle for eth_frame_port: MAC RX, client read, client write, MAC TX.
// Every valid/ready pair transfers on a clock edge where both are high; RX has no backpressure.
interface eth_frame_port_if;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       i_rx_last;
  logic       i_rx_err;
  logic       o_rx_drop;
  logic [7:0] o_rdata;
  logic       o_rready;
  logic       i_rreq;
  logic [7:0] i_wdata;
  logic       i_wvalid;
  logic       o_wready;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       o_tx_last;
  logic       i_tx_ready;
  logic [1:0] o_tx_state;

  modport slave (
    input  i_rx_data, i_rx_valid, i_rx_last, i_rx_err, i_rreq,
    input  i_wdata, i_wvalid, i_tx_ready,
    output o_rx_drop, o_rdata, o_rready, o_wready,
    output o_tx_data, o_tx_valid, o_tx_last, o_tx_state
  );

  modport master (
    output i_rx_data, i_rx_valid, i_rx_last, i_rx_err, i_rreq,
    output i_wdata, i_wvalid, i_tx_ready,
    input  o_rx_drop, o_rdata, o_rready, o_wready,
    input  o_tx_data, o_tx_valid, o_tx_last, o_tx_state
  );
endinterface

// File: rtl/eth_frame_port.sv
// Ethernet frame buffer: RX commits only complete error-free frames for client reads;
// TX gathers client bytes, closes the frame after an idle gap and streams it to the MAC.
module eth_frame_port #(
  parameter int AW  = 6,
  parameter int GAP = 4
) (
  input logic             i_clk,
  input logic             i_rst,
  eth_frame_port_if.slave bus
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [3:0]  GAP_C = 4'(GAP);

  typedef enum logic [1:0] {T_IDLE = 2'd0, T_FILL = 2'd1, T_SEND = 2'd2} tx_state_t;

  // ---------------- RX path ----------------
  logic [7:0]  r_rx_mem [2**AW];
  logic [AW:0] r_rx_wr, r_rx_commit, r_rd_ptr;
  logic        r_drop, r_rx_drop;
  logic [7:0]  r_rdata;
  logic        w_rx_full, w_rx_we, w_rx_bad, w_rready;

  assign w_rx_full = (r_rx_wr - r_rd_ptr) == DEPTH;
  assign w_rx_we   = bus.i_rx_valid && !w_rx_full && !r_drop;
  // A last byte that cannot be stored also spoils the frame.
  assign w_rx_bad  = bus.i_rx_err || r_drop || w_rx_full;
  assign w_rready  = r_rd_ptr != r_rx_commit;

  always_ff @(posedge i_clk) begin
    if (w_rx_we) r_rx_mem[r_rx_wr[AW-1:0]] <= bus.i_rx_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_wr     <= '0;
      r_rx_commit <= '0;
      r_rd_ptr    <= '0;
      r_drop      <= 1'b0;
      r_rx_drop   <= 1'b0;
      r_rdata     <= 8'h00;
    end else begin
      r_rx_drop <= 1'b0;
      if (bus.i_rx_valid) begin
        if (bus.i_rx_last) begin
          if (w_rx_bad) begin
            r_rx_wr   <= r_rx_commit;
            r_drop    <= 1'b0;
            r_rx_drop <= 1'b1;
          end else begin
            r_rx_wr     <= r_rx_wr + ONE;
            r_rx_commit <= r_rx_wr + ONE;
          end
        end else if (w_rx_full) begin
          r_drop <= 1'b1;
        end else if (!r_drop) begin
          r_rx_wr <= r_rx_wr + ONE;
        end
      end
      if (bus.i_rreq && w_rready) begin
        r_rdata  <= r_rx_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr <= r_rd_ptr + ONE;
      end
    end
  end

  assign bus.o_rx_drop = r_rx_drop;
  assign bus.o_rdata   = r_rdata;
  assign bus.o_rready  = w_rready;

  // ---------------- TX path ----------------
  logic [7:0]  r_tx_mem [2**AW];
  logic [AW:0] r_tx_wr, r_tx_rd;
  logic [3:0]  r_gap;
  tx_state_t   r_tx_state;

  tx_state_t   w_tx_state_nxt;
  logic [AW:0] w_tx_cnt, w_tx_cnt_nxt;
  logic [3:0]  w_gap_nxt;
  logic        w_tx_full, w_tx_acc, w_tx_adv, w_wready, w_tx_valid, w_tx_last;

  assign w_tx_cnt     = r_tx_wr - r_tx_rd;
  assign w_tx_full    = w_tx_cnt == DEPTH;
  assign w_tx_cnt_nxt = w_tx_cnt + {{AW{1'b0}}, w_tx_acc};

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_gap_nxt      = r_gap;
    w_tx_acc       = 1'b0;
    w_tx_adv       = 1'b0;
    w_wready       = 1'b0;
    w_tx_valid     = 1'b0;
    w_tx_last      = 1'b0;
    case (r_tx_state)
      T_IDLE: begin
        w_wready = 1'b1;
        if (bus.i_wvalid) begin
          w_tx_acc       = 1'b1;
          w_gap_nxt      = 4'd0;
          w_tx_state_nxt = T_FILL;
        end
      end
      T_FILL: begin
        w_wready = !w_tx_full;
        if (bus.i_wvalid && !w_tx_full) begin
          w_tx_acc  = 1'b1;
          w_gap_nxt = 4'd0;
        end else if (r_gap != 4'hF) begin
          w_gap_nxt = r_gap + 4'd1;
        end
        if (w_gap_nxt == GAP_C || w_tx_cnt_nxt == DEPTH) w_tx_state_nxt = T_SEND;
      end
      T_SEND: begin
        w_tx_valid = 1'b1;
        w_tx_last  = w_tx_cnt == ONE;
        if (bus.i_tx_ready) begin
          w_tx_adv = 1'b1;
          if (w_tx_last) w_tx_state_nxt = T_IDLE;
        end
      end
      default: w_tx_state_nxt = T_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_tx_acc) r_tx_mem[r_tx_wr[AW-1:0]] <= bus.i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_state <= T_IDLE;
      r_tx_wr    <= '0;
      r_tx_rd    <= '0;
      r_gap      <= 4'd0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_gap      <= w_gap_nxt;
      if (w_tx_acc) r_tx_wr <= r_tx_wr + ONE;
      if (w_tx_adv) r_tx_rd <= r_tx_rd + ONE;
    end
  end

  assign bus.o_wready   = w_wready;
  assign bus.o_tx_valid = w_tx_valid;
  assign bus.o_tx_last  = w_tx_last;
  assign bus.o_tx_data  = w_tx_valid ? r_tx_mem[r_tx_rd[AW-1:0]] : 8'h00;
  assign bus.o_tx_state = r_tx_state;
endmodule

// File: tb/tb_eth_frame_port.sv
// Bench for eth_frame_port: RX vector table, then hand-written overflow and TX sequences.
module tb_eth_frame_port;
  localparam int AW  = 6;
  localparam int GAP = 4;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  eth_frame_port_if bus ();
  eth_frame_port #(.AW(AW), .GAP(GAP)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       e;
    logic       rq;
    logic       x_rdy;
    logic [7:0] x_data;
    logic       x_drop;
  } rx_vec_t;
  rx_vec_t tbl[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic rx_drive(input logic v, input logic [7:0] d, input logic l, input logic e);
    bus.i_rx_valid = v;
    bus.i_rx_data  = d;
    bus.i_rx_last  = l;
    bus.i_rx_err   = e;
  endtask

  task automatic tx_write(input logic [7:0] b);
    check("wready_before_write", bus.o_wready, 1'b1);
    bus.i_wvalid = 1'b1;
    bus.i_wdata  = b;
    tick();
    bus.i_wvalid = 1'b0;
  endtask

  task automatic wait_tx_valid(input int max_cyc);
    for (int k = 0; k < max_cyc && !bus.o_tx_valid; k++) tick();
    check("tx_valid_wait", bus.o_tx_valid, 1'b1);
  endtask

  // n-byte frame of incrementing bytes; expect a discard when it cannot fit.
  task automatic rx_long(input int n, input logic exp_drop);
    for (int i = 0; i < n; i++) begin
      rx_drive(1'b1, 8'(i), i == n - 1, 1'b0);
      tick();
    end
    rx_drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("long_drop", bus.o_rx_drop, exp_drop);
    check("long_rready", bus.o_rready, !exp_drop);
    tick();
    check("long_drop_clear", bus.o_rx_drop, 1'b0);
  endtask

  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [7:0] exp_b;
    int         accepted;

    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0};
    tbl[6]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0};
    tbl[7]  = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0};
    tbl[9]  = '{1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hAA, 1'b0};
    tbl[11] = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0};
    tbl[12] = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 1'b0};
    tbl[16] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 1'b0};
    tbl[17] = '{1'b1, 8'h78, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h78, 1'b0};

    // Clock/reset
    i_rst = 1'b1;
    rx_drive(1'b0, 8'h00, 1'b0, 1'b0);
    bus.i_rreq = 1'b0;
    bus.i_wdata = 8'h00;
    bus.i_wvalid = 1'b0;
    bus.i_tx_ready = 1'b0;
    tick();
    tick();
    check("rst_rdata", bus.o_rdata, 8'h00);
    check("rst_rready", bus.o_rready, 1'b0);
    check("rst_rx_drop", bus.o_rx_drop, 1'b0);
    check("rst_tx_valid", bus.o_tx_valid, 1'b0);
    check("rst_tx_last", bus.o_tx_last, 1'b0);
    check("rst_tx_data", bus.o_tx_data, 8'h00);
    check("rst_tx_state", bus.o_tx_state, 2'd0);
    i_rst = 1'b0;
    tick();
    check("rst_wready", bus.o_wready, 1'b1);

    // RX vector table: good frame, bad frame, commit+read same cycle, over-read
    for (int i = 0; i < 20; i++) begin
      rx_drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].e);
      bus.i_rreq = tbl[i].rq;
      tick();
      check($sformatf("vec%0d_rready", i), bus.o_rready, tbl[i].x_rdy);
      check($sformatf("vec%0d_rdata", i), bus.o_rdata, tbl[i].x_data);
      check($sformatf("vec%0d_rx_drop", i), bus.o_rx_drop, tbl[i].x_drop);
    end
    rx_drive(1'b0, 8'h00, 1'b0, 1'b0);
    bus.i_rreq = 1'b0;
    tick();

    // Overflow on the last byte, overflow mid-frame, then exactly full
    rx_long(65, 1'b1);
    rx_long(70, 1'b1);
    rx_long(64, 1'b0);
    bus.i_rreq = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      check("full_frame_rdata", bus.o_rdata, 8'(i));
    end
    bus.i_rreq = 1'b0;
    check("full_frame_empty", bus.o_rready, 1'b0);

    // Good 2-byte frame after the overflows
    rx_drive(1'b1, 8'hC1, 1'b0, 1'b0);
    tick();
    rx_drive(1'b1, 8'hC2, 1'b1, 1'b0);
    tick();
    rx_drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("post_ovf_rready", bus.o_rready, 1'b1);
    bus.i_rreq = 1'b1;
    tick();
    check("post_ovf_b0", bus.o_rdata, 8'hC1);
    tick();
    check("post_ovf_b1", bus.o_rdata, 8'hC2);
    check("post_ovf_empty", bus.o_rready, 1'b0);
    bus.i_rreq = 1'b0;

    // TX: two bytes, gap close, ready held high
    bus.i_tx_ready = 1'b1;
    tx_write(8'h5A);
    tx_write(8'h01);
    for (int k = 1; k <= GAP; k++) begin
      tick();
      if (k < GAP) check("tx_gap_idle_valid", bus.o_tx_valid, 1'b0);
    end
    check("tx5_b0_valid", bus.o_tx_valid, 1'b1);
    check("tx5_b0_data", bus.o_tx_data, 8'h5A);
    check("tx5_b0_last", bus.o_tx_last, 1'b0);
    check("tx5_send_wready", bus.o_wready, 1'b0);
    tick();
    check("tx5_b1_valid", bus.o_tx_valid, 1'b1);
    check("tx5_b1_data", bus.o_tx_data, 8'h01);
    check("tx5_b1_last", bus.o_tx_last, 1'b1);
    tick();
    check("tx5_done_valid", bus.o_tx_valid, 1'b0);
    check("tx5_done_wready", bus.o_wready, 1'b1);

    // TX with toggling ready: stable while stalled, each byte exactly once
    bus.i_tx_ready = 1'b0;
    tx_write(8'hAB);
    tx_write(8'hCD);
    exp_q.push_back(8'hAB);
    exp_q.push_back(8'hCD);
    wait_tx_valid(12);
    prev_stall = 1'b0;
    prev_data = 8'h00;
    prev_last = 1'b0;
    accepted = 0;
    for (int c = 0; c < 20 && (exp_q.size() != 0 || bus.o_tx_valid); c++) begin
      if (prev_stall) begin
        check("tx_stall_valid", bus.o_tx_valid, 1'b1);
        check("tx_stall_data", bus.o_tx_data, prev_data);
        check("tx_stall_last", bus.o_tx_last, prev_last);
      end
      bus.i_tx_ready = c[0];
      if (bus.o_tx_valid && bus.i_tx_ready) begin
        accepted++;
        if (exp_q.size() != 0) begin
          exp_b = exp_q.pop_front();
          check("tx_toggle_data", bus.o_tx_data, exp_b);
          check("tx_toggle_last", bus.o_tx_last, exp_q.size() == 0);
        end
      end
      prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
      prev_data  = bus.o_tx_data;
      prev_last  = bus.o_tx_last;
      tick();
    end
    check("tx_toggle_count", accepted, 2);
    check("tx_toggle_pending", exp_q.size(), 0);
    check("tx_toggle_end_valid", bus.o_tx_valid, 1'b0);

    // TX buffer fills: send starts at full, extra writes ignored
    bus.i_tx_ready = 1'b0;
    for (int i = 0; i < 64; i++) tx_write(8'(i + 8'h40));
    check("txfull_state_send", bus.o_tx_valid, 1'b1);
    check("txfull_wready", bus.o_wready, 1'b0);
    bus.i_wvalid = 1'b1;
    bus.i_wdata = 8'hFF;
    tick();
    bus.i_wvalid = 1'b0;
    bus.i_tx_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      check("txfull_data", bus.o_tx_data, 8'(i + 8'h40));
      check("txfull_last", bus.o_tx_last, i == 63);
      tick();
    end
    check("txfull_done_valid", bus.o_tx_valid, 1'b0);
    check("txfull_done_wready", bus.o_wready, 1'b1);

    // Reset mid-send with an unread RX frame pending
    rx_drive(1'b1, 8'h99, 1'b1, 1'b0);
    tick();
    rx_drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("pre_rst_rready", bus.o_rready, 1'b1);
    bus.i_tx_ready = 1'b0;
    tx_write(8'h10);
    tx_write(8'h20);
    tx_write(8'h30);
    wait_tx_valid(12);
    i_rst = 1'b1;
    tick();
    check("midrst_tx_valid", bus.o_tx_valid, 1'b0);
    check("midrst_tx_last", bus.o_tx_last, 1'b0);
    check("midrst_tx_data", bus.o_tx_data, 8'h00);
    check("midrst_rready", bus.o_rready, 1'b0);
    check("midrst_rdata", bus.o_rdata, 8'h00);
    i_rst = 1'b0;
    tick();
    check("postrst_wready", bus.o_wready, 1'b1);
    check("postrst_tx_valid", bus.o_tx_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/eth_frame_port.md
Name: eth_frame_port

Overview:
Ethernet-side frame buffer serving the client read/write byte interface used by protocol handlers such as the link/ping responder. RX path buffers each MAC frame payload and exposes only complete, error-free frames through a read-request port. TX path collects client bytes, closes a frame after an idle gap, and streams it to the MAC with ready/valid/last.

Parameters:
AW, 6, log2 of RX and TX buffer depth; each buffer holds 2**AW bytes
GAP, 4, idle client cycles after the last written byte that close a TX frame (1..15)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_rx_data  in  8  MAC RX payload byte
i_rx_valid  in  1  RX byte valid; no backpressure
i_rx_last  in  1  qualifies final byte of frame
i_rx_err  in  1  sampled with i_rx_last; 1 = discard frame
o_rx_drop  out  1  one-cycle pulse when a frame is discarded
o_rdata  out  8  client read byte
o_rready  out  1  at least one committed byte available
i_rreq  in  1  client read request
i_wdata  in  8  client write byte
i_wvalid  in  1  client write strobe
o_wready  out  1  write byte accepted this cycle
o_tx_data  out  8  MAC TX byte
o_tx_valid  out  1  MAC TX byte valid
o_tx_last  out  1  final byte of TX frame
i_tx_ready  in  1  MAC accepts byte

Behaviour:
- Reset i_rst, synchronous, active-high; clock i_clk.
- On reset, all pointers clear, RX drop flag clears, and TX state goes to T_IDLE.
- Reset output values: o_rdata=0, o_rready=0, o_rx_drop=0, o_tx_valid=0, o_tx_last=0, o_tx_data=0. o_wready=1 from the first cycle after reset.
- Reset mid-frame discards all buffered RX and TX data.
- RX pointers are AW+1 bits: wr_ptr, commit_ptr, rd_ptr. Full when wr_ptr-rd_ptr == 2**AW.
- RX byte write: i_rx_valid and not full and not drop flag -> store byte, wr_ptr+1.
- RX overflow: i_rx_valid while full -> set drop flag. Ignore bytes until i_rx_last.
- RX frame end: i_rx_valid and i_rx_last.
  - Commits the frame (commit_ptr <= wr_ptr including this byte) only if !i_rx_err and drop flag clear.
  - Otherwise wr_ptr <= commit_ptr, o_rx_drop pulses the next cycle, and drop flag clears.
- Zero-length frames cannot occur; the last byte is always a payload byte.
- o_rready = (rd_ptr != commit_ptr), decoded from registered pointers. It goes high the cycle after the committing edge.
- Client read: i_rreq and o_rready -> o_rdata <= mem[rd_ptr], rd_ptr+1. Data is valid the cycle after the request (1-cycle latency).
- i_rreq while !o_rready: no pointer change, o_rdata holds. This over-read is legal and harmless.
- Commit and read in the same cycle are both applied.
- TX FSM, T_IDLE:
  - o_wready=1.
  - i_wvalid -> write byte, gap counter=0, go to T_FILL.
- TX FSM, T_FILL:
  - o_wready = !full.
  - Accepted byte -> gap counter=0.
  - Otherwise gap counter+1 (saturating).
  - Counter reaches GAP, or buffer becomes full -> go to T_SEND.
  - i_wvalid while full: byte dropped, no state effect.
- TX FSM, T_SEND:
  - o_wready=0; client writes are ignored.
  - o_tx_valid=1 and o_tx_data=mem[tx_rd] (show-ahead).
  - o_tx_last=1 when one byte remains.
  - i_tx_ready advances tx_rd.
  - Accepting the last byte -> T_IDLE; o_tx_valid=0 the next cycle.
- o_tx_valid, o_tx_data and o_tx_last hold stable while !i_tx_ready.
- RX and TX paths are fully independent and may operate concurrently.

Test Plan:
1. RX frame 0x11,0x22,0x33 (last on 0x33, err=0) -> o_rready=1 one cycle after last. Three i_rreq cycles -> o_rdata 0x11,0x22,0x33 each one cycle after its request; o_rready=0 after the third read.
2. RX frame with i_rx_err=1 on last -> o_rx_drop single pulse, o_rready stays 0. A following good frame 0xAA -> read returns 0xAA.
3. RX 65-byte frame with AW=6 and nothing read -> overflow, o_rx_drop pulse, o_rready=0, buffer empty. The next 2-byte frame reads back correctly.
4. Client holds i_rreq continuously across an empty buffer -> rd_ptr does not move and o_rdata holds its last value. A subsequent frame still reads in order.
5. Client writes 0x5A, 0x01 on consecutive cycles, then idles; i_tx_ready=1 -> after GAP=4 idle cycles o_tx_valid=1 with 0x5A, then 0x01 with o_tx_last=1. o_wready=0 during T_SEND and 1 after.
6. Repeat scenario 5 with i_tx_ready toggling 0/1 -> outputs stable while stalled and both bytes delivered exactly once. Reset asserted mid-T_SEND -> o_tx_valid=0 next cycle and o_wready=1 after reset.
